// File: rtl/chunked_add_seq_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and slice width.
package chunked_add_seq_pkg;

  localparam int unsigned SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_add_seq_add3_slice.sv
// Combinational 3-bit ripple-carry adder built from three full adders.
module add3_slice
  import chunked_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co = c[SLICE_W];
  end

endmodule

// File: rtl/chunked_add_seq.sv
// Sequential WIDTH-bit adder that reuses one 3-bit slice, one chunk per cycle, LSB first.
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNKS = WIDTH / SLICE_W;
  localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   sum_next;
  logic               ovf_next;
  logic               accept;

  // Select the current chunk and merge the slice result into the partial sum.
  always_comb begin
    slice_a  = a_reg[cnt*SLICE_W +: SLICE_W];
    slice_b  = b_reg[cnt*SLICE_W +: SLICE_W];
    sum_next = sum_reg;
    sum_next[cnt*SLICE_W +: SLICE_W] = slice_s;
    ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
    accept   = start && !abort;
  end

  add3_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // IDLE and DONE share the accept path so DONE can restart back-to-back.
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt       <= '0;
            sum_reg   <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            sum_reg   <= sum_next;
            carry_reg <= slice_co;
            if (cnt == LAST) begin
              sum   <= sum_next;
              cout  <= slice_co;
              ovf   <= ovf_next;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
